// File: rtl/pwm_generator_mc.sv
// pwm_generator_mc: multi-channel PWM with shared edge/center-aligned counter
// and shadowed configuration that swaps in only at period boundaries.
module pwm_generator_mc #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 32
) (
    input  logic                   Clk50M,
    input  logic                   Rst,
    input  logic                   cnt_en,
    input  logic [CNT_W-1:0]       counter_arr,
    input  logic [N_CH*CNT_W-1:0]  counter_ccr,
    input  logic                   center_mode,
    input  logic [N_CH-1:0]        pol,
    input  logic                   load,
    output logic [N_CH-1:0]        o_pwm,
    output logic                   o_update,
    output logic [CNT_W-1:0]       o_cnt,
    output logic                   o_dir
);
    logic [CNT_W-1:0]      cnt_q, cnt_d, arr_q, arr_d;
    logic [N_CH*CNT_W-1:0] ccr_q, ccr_d;
    logic [N_CH-1:0]       pol_q, pol_d, pwm_q, pwm_d;
    logic                  dir_q, dir_d, mode_q, mode_d, pend_q, pend_d, upd_q, upd_d;
    logic                  evt, cap;

    always_comb begin
        evt    = cnt_en && (mode_q ? (arr_q == '0 || (dir_q && cnt_q == CNT_W'(1))) : cnt_q == arr_q);
        cap    = pend_q && (evt || !cnt_en);
        upd_d  = evt;
        pend_d = cap ? 1'b0 : (pend_q | load);
        arr_d  = cap ? counter_arr : arr_q;
        ccr_d  = cap ? counter_ccr : ccr_q;
        mode_d = cap ? center_mode : mode_q;
        pol_d  = cap ? pol : pol_q;
        // dir goes high on the cycle the counter reaches the top, so the 1->0 step is the boundary
        cnt_d  = !cnt_en ? (cap ? '0 : cnt_q) :
                 evt ? '0 :
                 (mode_q && dir_q) ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
        dir_d  = !cnt_en ? (cap ? 1'b0 : dir_q) :
                 evt ? 1'b0 :
                 mode_q && (dir_q || cnt_q + CNT_W'(1) == arr_q);
        pwm_d  = '0;
        for (int i = 0; i < N_CH; i++)
            pwm_d[i] = (cnt_q < ccr_q[i*CNT_W +: CNT_W]) ^ pol_q[i];
    end

    always_ff @(posedge Clk50M) begin
        if (Rst) begin
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            pwm_q  <= '0;
            upd_q  <= 1'b0;
            arr_q  <= '0;
            ccr_q  <= '0;
            mode_q <= 1'b0;
            pol_q  <= '0;
            pend_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            pwm_q  <= pwm_d;
            upd_q  <= upd_d;
            arr_q  <= arr_d;
            ccr_q  <= ccr_d;
            mode_q <= mode_d;
            pol_q  <= pol_d;
            pend_q <= pend_d;
        end
    end

    assign o_pwm    = pwm_q;
    assign o_update = upd_q;
    assign o_cnt    = cnt_q;
    assign o_dir    = dir_q;
endmodule

// File: tb/tb_pwm_generator_mc.sv
// tb_pwm_generator_mc: directed and random stimulus checked against a
// period-phase reference model of the multi-channel PWM generator.
module tb_pwm_generator_mc;
    localparam int N = 4;
    localparam int W = 32;

    logic           Clk50M = 1'b0;
    logic           Rst = 1'b1;
    logic           cnt_en = 1'b0;
    logic           center_mode = 1'b0;
    logic           load = 1'b0;
    logic [W-1:0]   counter_arr = '0;
    logic [N*W-1:0] counter_ccr = '0;
    logic [N-1:0]   pol = '0;
    logic [N-1:0]   o_pwm;
    logic           o_update, o_dir;
    logic [W-1:0]   o_cnt;

    int passed = 0, fails = 0, total = 0;
    int hi, ups;

    // model state: phase within the current period plus the active configuration
    longint   m_p, m_arr;
    longint   m_ccr [N];
    bit       m_mode, m_pend, m_upd;
    bit [N-1:0] m_pol, m_pwm;

    pwm_generator_mc #(.N_CH(N), .CNT_W(W)) dut (
        .Clk50M(Clk50M), .Rst(Rst), .cnt_en(cnt_en), .counter_arr(counter_arr),
        .counter_ccr(counter_ccr), .center_mode(center_mode), .pol(pol), .load(load),
        .o_pwm(o_pwm), .o_update(o_update), .o_cnt(o_cnt), .o_dir(o_dir)
    );

    always #5 Clk50M = ~Clk50M;

    function automatic longint period();
        return m_mode ? (m_arr == 0 ? 1 : 2 * m_arr) : m_arr + 1;
    endfunction

    function automatic longint cnt_now();
        return (m_mode && m_p > m_arr) ? 2 * m_arr - m_p : m_p;
    endfunction

    function automatic bit dir_now();
        return m_mode && m_p > 0 && m_p >= m_arr;
    endfunction

    task automatic model_tick();
        longint c;
        bit evt, cap;
        if (Rst) begin
            m_p = 0; m_arr = 0; m_mode = 0; m_pol = '0; m_pwm = '0; m_upd = 0; m_pend = 1;
            for (int i = 0; i < N; i++) m_ccr[i] = 0;
            return;
        end
        c   = cnt_now();
        evt = cnt_en && (m_p == period() - 1);
        for (int i = 0; i < N; i++) m_pwm[i] = (c < m_ccr[i]) ^ m_pol[i];
        m_upd = evt;
        cap   = m_pend && (evt || !cnt_en);
        if (cnt_en) m_p = evt ? 0 : m_p + 1;
        else if (cap) m_p = 0;
        if (cap) begin
            m_arr  = longint'(counter_arr);
            m_mode = center_mode;
            m_pol  = pol;
            for (int i = 0; i < N; i++) m_ccr[i] = longint'(counter_ccr[i*W +: W]);
        end
        m_pend = cap ? 1'b0 : (m_pend | load);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk50M);
        model_tick();
        #1;
        check("cnt", o_cnt, 32'(cnt_now()));
        check("dir", 32'(o_dir), 32'(dir_now()));
        check("pwm", 32'(o_pwm), 32'(m_pwm));
        check("update", 32'(o_update), 32'(m_upd));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic measure(input int n, input int ch);
        hi = 0; ups = 0;
        for (int k = 0; k < n; k++) begin
            step();
            hi  += int'(o_pwm[ch]);
            ups += int'(o_update);
        end
    endtask

    task automatic set_ccr(input int a, input int b, input int c, input int d);
        counter_ccr = {32'(d), 32'(c), 32'(b), 32'(a)};
    endtask

    task automatic strobe_load();
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        // reset: outputs zero regardless of polarity
        pol = 4'b1111;
        run(2);
        check("rst_pwm", 32'(o_pwm), 32'd0);

        // edge-aligned, arr=4, ccr={0,2,4,7}
        Rst = 1'b0; pol = '0; counter_arr = 4; center_mode = 0; set_ccr(0, 2, 4, 7);
        cnt_en = 1'b1;
        strobe_load();
        run(3);
        measure(10, 1);
        check("edge_ch1_high", hi, 4);
        check("edge_updates", ups, 2);
        measure(10, 0);
        check("edge_ch0_high", hi, 0);
        measure(10, 3);
        check("edge_ch3_high", hi, 10);
        measure(10, 2);
        check("edge_ch2_high", hi, 8);

        // center-aligned, arr=4, ccr1=2
        center_mode = 1; set_ccr(1, 2, 3, 5);
        strobe_load();
        run(12);
        measure(16, 1);
        check("center_ch1_high", hi, 6);
        check("center_updates", ups, 2);

        // shadow behaviour: ccr change with load, then without load
        center_mode = 0; counter_arr = 9; set_ccr(3, 3, 3, 3);
        strobe_load();
        run(14);
        set_ccr(6, 6, 6, 6);
        strobe_load();
        run(25);
        set_ccr(1, 8, 0, 9);
        run(12);
        measure(10, 0);
        check("no_load_ch0_high", hi, 6);

        // polarity inversion on ch1
        counter_arr = 4; set_ccr(0, 2, 0, 0); pol = 4'b0010;
        strobe_load();
        run(8);
        measure(10, 1);
        check("pol_ch1_high", hi, 6);
        Rst = 1'b1;
        step();
        check("pol_rst_pwm", 32'(o_pwm), 32'd0);
        Rst = 1'b0;
        run(7);

        // freeze mid-period, reload arr=7 while stopped, then resume
        cnt_en = 1'b0;
        run(3);
        counter_arr = 7;
        strobe_load();
        run(2);
        check("frozen_cnt", o_cnt, 32'd0);
        cnt_en = 1'b1;
        run(20);

        // reset mid-period in center mode, then restart with pending config
        center_mode = 1; counter_arr = 5; set_ccr(2, 3, 4, 6); pol = 4'b0101;
        strobe_load();
        run(13);
        Rst = 1'b1;
        step();
        check("rst_cnt", o_cnt, 32'd0);
        check("rst_update", 32'(o_update), 32'd0);
        Rst = 1'b0;
        run(20);

        // randomized configuration, enable, load and reset traffic
        for (int k = 0; k < 600; k++) begin
            Rst         = ($urandom_range(99) == 0);
            cnt_en      = ($urandom_range(9) != 0);
            load        = ($urandom_range(7) == 0);
            counter_arr = 32'($urandom_range(10));
            center_mode = 1'($urandom_range(1));
            pol         = 4'($urandom);
            set_ccr(int'($urandom_range(12)), int'($urandom_range(12)),
                    int'($urandom_range(12)), int'($urandom_range(12)));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
